// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: fixed-period servo pulse generator.
// The compare value is sampled, clamped into [MIN_CMP, MAX_CMP] and latched
// only at a period boundary. This keeps every pulse whole even while the
// upstream ramp is moving. period_start marks the first clk cycle of each
// period and is meant to be the ramp's step enable.
module servo_pwm_gen #(
    parameter int CNTR_BITS = 16,
    parameter int PRESCALE  = 100,
    parameter int PERIOD    = 20000,
    parameter int MIN_CMP   = 1000,
    parameter int MAX_CMP   = 2000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CNTR_BITS-1:0] cmp_in,
    output logic                 pwm_out,
    output logic                 period_start,
    output logic [CNTR_BITS-1:0] cmp_active,
    output logic                 clamped
);

    // Elaboration-time parameter sanity checks
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("servo_pwm_gen: PRESCALE must be >= 1");
    end
    if (MIN_CMP < 1) begin : g_bad_min
        $error("servo_pwm_gen: MIN_CMP must be >= 1");
    end
    if (MIN_CMP > MAX_CMP) begin : g_bad_minmax
        $error("servo_pwm_gen: MIN_CMP must not exceed MAX_CMP");
    end
    if (MAX_CMP > PERIOD) begin : g_bad_max
        $error("servo_pwm_gen: MAX_CMP must not exceed PERIOD");
    end
    if (longint'(PERIOD) >= (longint'(1) << CNTR_BITS)) begin : g_bad_period
        $error("servo_pwm_gen: PERIOD must fit in CNTR_BITS");
    end

    localparam int PRES_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRES_W-1:0]    PRES_LAST = PRES_W'(PRESCALE - 1);
    localparam logic [CNTR_BITS-1:0] CNT_LAST  = CNTR_BITS'(PERIOD - 1);
    localparam logic [CNTR_BITS-1:0] MIN_C     = CNTR_BITS'(MIN_CMP);
    localparam logic [CNTR_BITS-1:0] MAX_C     = CNTR_BITS'(MAX_CMP);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [PRES_W-1:0]      r_pres;
    logic [PRES_W-1:0]      w_pres_nxt;
    logic [CNTR_BITS-1:0]   r_cnt;
    logic [CNTR_BITS-1:0]   w_cnt_nxt;

    logic                   r_pwm;
    logic                   w_pwm_nxt;
    logic                   r_period_start;
    logic                   w_period_start_nxt;
    logic [CNTR_BITS-1:0]   r_cmp;
    logic [CNTR_BITS-1:0]   w_cmp_nxt;
    logic                   r_clamped;
    logic                   w_clamped_nxt;

    logic [CNTR_BITS-1:0]   w_cmp_clamp;
    logic                   w_cmp_was_clamped;
    logic                   w_tick;
    logic                   w_wrap;

    // Clamp the requested width into the safe window (unsigned compare)
    always_comb begin
        w_cmp_clamp       = cmp_in;
        w_cmp_was_clamped = 1'b0;
        if (cmp_in < MIN_C) begin
            w_cmp_clamp       = MIN_C;
            w_cmp_was_clamped = 1'b1;
        end else if (cmp_in > MAX_C) begin
            w_cmp_clamp       = MAX_C;
            w_cmp_was_clamped = 1'b1;
        end
    end

    assign w_tick = (r_pres == PRES_LAST);
    assign w_wrap = w_tick && (r_cnt == CNT_LAST);

    // Next-state and next-output logic
    // Outputs are registered, so pwm is derived from the next counter and
    // compare values. That keeps pwm_out aligned with the cnt it reflects.
    always_comb begin
        w_state_nxt        = r_state;
        w_pres_nxt         = r_pres;
        w_cnt_nxt          = r_cnt;
        w_pwm_nxt          = 1'b0;
        w_period_start_nxt = 1'b0;
        w_cmp_nxt          = r_cmp;
        w_clamped_nxt      = r_clamped;

        unique case (r_state)
            S_IDLE: begin
                w_pres_nxt = '0;
                w_cnt_nxt  = '0;
                if (en) begin
                    w_state_nxt        = S_RUN;
                    w_cmp_nxt          = w_cmp_clamp;
                    w_clamped_nxt      = w_cmp_was_clamped;
                    w_period_start_nxt = 1'b1;
                    // Clamped compare is at least MIN_CMP >= 1, so P0 is high
                    w_pwm_nxt          = 1'b1;
                end
            end

            S_RUN: begin
                if (w_wrap) begin
                    w_pres_nxt = '0;
                    w_cnt_nxt  = '0;
                    if (en) begin
                        w_cmp_nxt          = w_cmp_clamp;
                        w_clamped_nxt      = w_cmp_was_clamped;
                        w_period_start_nxt = 1'b1;
                        w_pwm_nxt          = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    if (w_tick) begin
                        w_pres_nxt = '0;
                        w_cnt_nxt  = r_cnt + CNTR_BITS'(1);
                    end else begin
                        w_pres_nxt = r_pres + PRES_W'(1);
                    end
                    w_pwm_nxt = (w_cnt_nxt < r_cmp);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_pres_nxt  = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_pres         <= '0;
            r_cnt          <= '0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
            r_cmp          <= '0;
            r_clamped      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pres         <= w_pres_nxt;
            r_cnt          <= w_cnt_nxt;
            r_pwm          <= w_pwm_nxt;
            r_period_start <= w_period_start_nxt;
            r_cmp          <= w_cmp_nxt;
            r_clamped      <= w_clamped_nxt;
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
    assign cmp_active   = r_cmp;
    assign clamped      = r_clamped;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with small parameters (80-cycle period).
module tb_servo_pwm_gen;

    localparam int CB  = 8;
    localparam int PLEN = 80;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [CB-1:0] cmp_in;
    logic          pwm_out;
    logic          period_start;
    logic [CB-1:0] cmp_active;
    logic          clamped;

    int errors;
    int checks;

    servo_pwm_gen #(
        .CNTR_BITS(CB),
        .PRESCALE (4),
        .PERIOD   (20),
        .MIN_CMP  (2),
        .MAX_CMP  (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cmp_in      (cmp_in),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .cmp_active  (cmp_active),
        .clamped     (clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Steps until period_start is seen (bounded); lat = negedges waited
    task automatic wait_p0(output int lat);
        lat = 0;
        while (period_start !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Called at a P0 sample; walks one full period checking pulse shape,
    // strobe position and compare stability, applying optional input changes
    task automatic measure(input int exp_hi, input int chg_idx, input logic [CB-1:0] chg_val,
                           input int en_idx, output int hi, output logic shape_ok);
        logic [CB-1:0] cmp0;
        hi = 0;
        shape_ok = 1'b1;
        cmp0 = cmp_active;
        for (int i = 0; i < PLEN; i++) begin
            if (i == chg_idx) cmp_in = chg_val;
            if (i == en_idx) en = 1'b0;
            if (pwm_out === 1'b1) hi++;
            if (pwm_out !== (i < exp_hi)) shape_ok = 1'b0;
            if (period_start !== (i == 0)) shape_ok = 1'b0;
            if (cmp_active !== cmp0) shape_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int hi;
        int cnt_ps;
        int cnt_pwm;
        logic ok;

        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        cmp_in = 8'd7;

        // Reset held 3 cycles with en=1
        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_ps", 32'(period_start), 0);
        chk("rst_cmp", 32'(cmp_active), 0);
        chk("rst_clamped", 32'(clamped), 0);

        rst_n = 1'b1;
        wait_p0(lat);
        chk("start_latency", lat, 1);
        chk("first_cmp", 32'(cmp_active), 7);
        chk("first_pwm", 32'(pwm_out), 1);
        cmp_in = 8'd5;
        measure(28, -1, '0, -1, hi, ok);
        chk("p7_hi", hi, 28);
        chk("p7_shape", 32'(ok), 1);
        chk("p7_next_ps", 32'(period_start), 1);

        // Nominal 5
        chk("p5_cmp", 32'(cmp_active), 5);
        chk("p5_clamped", 32'(clamped), 0);
        cmp_in = 8'd1;
        measure(20, -1, '0, -1, hi, ok);
        chk("p5_hi", hi, 20);
        chk("p5_shape", 32'(ok), 1);
        chk("p5_next_ps", 32'(period_start), 1);

        // Low clamp
        chk("lo_cmp", 32'(cmp_active), 2);
        chk("lo_clamped", 32'(clamped), 1);
        cmp_in = 8'd50;
        measure(8, -1, '0, -1, hi, ok);
        chk("lo_hi", hi, 8);
        chk("lo_shape", 32'(ok), 1);

        // High clamp
        chk("hi_cmp", 32'(cmp_active), 10);
        chk("hi_clamped", 32'(clamped), 1);
        cmp_in = 8'd5;
        measure(40, -1, '0, -1, hi, ok);
        chk("hi_hi", hi, 40);
        chk("hi_shape", 32'(ok), 1);

        // Mid-period update 5 -> 9 at cycle 30
        chk("mid_cmp", 32'(cmp_active), 5);
        chk("mid_clamped", 32'(clamped), 0);
        measure(20, 30, 8'd9, -1, hi, ok);
        chk("mid_hi", hi, 20);
        chk("mid_shape", 32'(ok), 1);
        chk("mid_next_ps", 32'(period_start), 1);

        // Next period uses 9; en drops at cycle 10, period still completes
        chk("nine_cmp", 32'(cmp_active), 9);
        measure(36, -1, '0, 10, hi, ok);
        chk("stop_hi", hi, 36);
        chk("stop_shape", 32'(ok), 1);
        chk("stop_no_ps", 32'(period_start), 0);
        chk("stop_pwm", 32'(pwm_out), 0);

        cnt_ps = 0;
        cnt_pwm = 0;
        for (int i = 0; i < 30; i++) begin
            if (period_start !== 1'b0) cnt_ps++;
            if (pwm_out !== 1'b0) cnt_pwm++;
            @(negedge clk);
        end
        chk("idle_ps_count", cnt_ps, 0);
        chk("idle_pwm_count", cnt_pwm, 0);

        // Restart
        cmp_in = 8'd3;
        en = 1'b1;
        wait_p0(lat);
        chk("restart_latency", lat, 1);
        chk("restart_cmp", 32'(cmp_active), 3);
        chk("restart_pwm", 32'(pwm_out), 1);

        // Reset at cycle 5 of the pulse
        repeat (5) @(negedge clk);
        chk("pre_rst_pwm", 32'(pwm_out), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_pwm", 32'(pwm_out), 0);
        chk("mrst_ps", 32'(period_start), 0);
        chk("mrst_cmp", 32'(cmp_active), 0);
        rst_n = 1'b1;
        wait_p0(lat);
        chk("mrst_latency", lat, 1);
        chk("mrst_new_cmp", 32'(cmp_active), 3);
        measure(12, -1, '0, -1, hi, ok);
        chk("mrst_hi", hi, 12);
        chk("mrst_shape", 32'(ok), 1);
        chk("mrst_next_ps", 32'(period_start), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
